// File: rtl/fx3_rx_state_machine.sv
// FX3 slave-FIFO thread-1 reader: pulls host words into the local command FIFO.
// Define FX3_RX_OVERFLOW_DETECT_EN to enable the sticky rxOverflow detector.
module fx3_rx_state_machine #(
  parameter int READ_LATENCY = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  fx3_clock,
  input  logic                  fx3_nReset,
  input  logic                  fx3_th1Ready,
  input  logic                  fx3_th1Watermark,
  input  logic [DATA_WIDTH-1:0] fx3_data,
  input  logic                  fifoAlmostFull,
  input  logic                  rxEnable,
  output logic                  fx3_nOE,
  output logic                  fx3_nRead,
  output logic                  fifoWrite,
  output logic [DATA_WIDTH-1:0] fifoData,
  output logic                  rxBusy,
  output logic                  rxOverflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT_WM = 3'd2,
    S_READ    = 3'd3,
    S_DRAIN   = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_th1Ready;
  logic                  r_th1Watermark;
  logic                  r_fifoAlmostFull;
  logic                  r_nOE;
  logic                  r_nRead;
  logic                  r_busy;
  logic [READ_LATENCY:0] r_trk;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_nOE;
  logic                  w_nRead;
  logic                  w_trkEmpty;

  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      r_th1Ready       <= 1'b0;
      r_th1Watermark   <= 1'b0;
      r_fifoAlmostFull <= 1'b0;
    end else begin
      r_th1Ready       <= fx3_th1Ready;
      r_th1Watermark   <= fx3_th1Watermark;
      r_fifoAlmostFull <= fifoAlmostFull;
    end
  end

  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // A read still on the pad counts as in flight until it enters the tracker.
  assign w_trkEmpty = (r_trk == '0) && r_nRead;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (rxEnable && r_th1Ready && !r_fifoAlmostFull)
          w_next = S_ARM;
      S_ARM:
        w_next = S_WAIT_WM;
      S_WAIT_WM:
        if (!r_th1Ready || !rxEnable) w_next = S_GAP;
        else if (r_th1Watermark)      w_next = S_READ;
      S_READ:
        if (!r_th1Watermark || r_fifoAlmostFull || !rxEnable)
          w_next = S_DRAIN;
      S_DRAIN:
        if (w_trkEmpty) w_next = S_GAP;
      S_GAP:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_nOE   = 1'b1;
    w_nRead = 1'b1;
    case (r_state)
      S_ARM, S_WAIT_WM, S_DRAIN: w_nOE = 1'b0;
      S_READ: begin
        w_nOE   = 1'b0;
        w_nRead = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      r_nOE   <= 1'b1;
      r_nRead <= 1'b1;
      r_busy  <= 1'b0;
      r_trk   <= '0;
      r_data  <= '0;
    end else begin
      r_nOE   <= w_nOE;
      r_nRead <= w_nRead;
      r_busy  <= (r_state != S_IDLE);
      r_trk   <= {r_trk[READ_LATENCY-1:0], ~r_nRead};
      r_data  <= fx3_data;
    end
  end

  assign fx3_nOE   = r_nOE;
  assign fx3_nRead = r_nRead;
  assign rxBusy    = r_busy;
  assign fifoWrite = r_trk[READ_LATENCY];
  assign fifoData  = r_data;

`ifdef FX3_RX_OVERFLOW_DETECT_EN
  logic [3:0] r_afCnt;
  logic       r_ovf;

  // r_afCnt: completed consecutive cycles of registered almost-full.
  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      r_afCnt <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (!r_fifoAlmostFull)  r_afCnt <= '0;
      else if (r_afCnt != '1) r_afCnt <= r_afCnt + 4'd1;
      if (fifoWrite && (r_afCnt > 4'(READ_LATENCY + 2)))
        r_ovf <= 1'b1;
    end
  end

  assign rxOverflow = r_ovf;
`else
  assign rxOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fx3_rx_state_machine.sv
// Randomised bench for fx3_rx_state_machine against an FX3 bus model
// and a word scoreboard.
module tb_fx3_rx_state_machine;

  localparam int LAT = 2;

`ifdef FX3_RX_OVERFLOW_DETECT_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        wm = 1'b0;
  logic [15:0] fx3_data = '0;
  logic        af = 1'b0;
  logic        en = 1'b0;
  logic        fx3_nOE;
  logic        fx3_nRead;
  logic        fifoWrite;
  logic [15:0] fifoData;
  logic        rxBusy;
  logic        rxOverflow;

  int          n_vec = 0;
  int          n_err = 0;
  int          edges = 0;
  int          reads = 0;
  int          writes = 0;
  int          r0;
  logic [15:0] word = 16'h0001;
  logic        wexp;

  int          dq[$];
  logic [15:0] dw[$];
  int          wq[$];
  logic [15:0] exq[$];

  fx3_rx_state_machine #(
    .READ_LATENCY(LAT),
    .DATA_WIDTH  (16)
  ) dut (
    .fx3_clock       (clk),
    .fx3_nReset      (rst_n),
    .fx3_th1Ready    (ready),
    .fx3_th1Watermark(wm),
    .fx3_data        (fx3_data),
    .fifoAlmostFull  (af),
    .rxEnable        (en),
    .fx3_nOE         (fx3_nOE),
    .fx3_nRead       (fx3_nRead),
    .fifoWrite       (fifoWrite),
    .fifoData        (fifoData),
    .rxBusy          (rxBusy),
    .rxOverflow      (rxOverflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FX3 model: a read sampled at edge e puts its word on the bus for
  // edge e+LAT; the FIFO must see it strobed at edge e+LAT+1.
  always @(negedge clk) begin
    if (!rst_n) begin
      dq.delete();
      dw.delete();
      wq.delete();
      exq.delete();
    end else begin
      wexp = (wq.size() > 0) && (wq[0] == edges);
      if (wexp) void'(wq.pop_front());
      if (fifoWrite || wexp) chk("wr_strobe", 32'(fifoWrite), 32'(wexp));
      if (fifoWrite) begin
        writes++;
        if (exq.size() == 0) chk("wr_queue", 32'(exq.size()), 1);
        else chk("wr_data", 32'(fifoData), 32'(exq.pop_front()));
      end
      if (!fx3_nRead) begin
        chk("nrd_noe", 32'(fx3_nOE), 0);
        reads++;
        dq.push_back(edges + LAT);
        dw.push_back(word);
        exq.push_back(word);
        wq.push_back(edges + LAT + 1);
        word = word + 16'd1;
      end
      if (dq.size() > 0 && dq[0] == edges) begin
        void'(dq.pop_front());
        fx3_data = dw.pop_front();
      end else begin
        fx3_data = 16'($urandom);
      end
    end
  end

  task automatic wait_reads(input int target, input string tag);
    for (int i = 0; i < 400 && reads < target; i++) @(negedge clk);
    chk(tag, 32'(reads >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400 && rxBusy; i++) @(negedge clk);
    chk(tag, 32'(rxBusy), 0);
  endtask

  task automatic wait_noe_low(input string tag);
    for (int i = 0; i < 100 && fx3_nOE; i++) @(negedge clk);
    chk(tag, 32'(fx3_nOE), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_noe", 32'(fx3_nOE), 1);
    chk("rst_nrd", 32'(fx3_nRead), 1);
    chk("rst_wr", 32'(fifoWrite), 0);
    chk("rst_data", 32'(fifoData), 0);
    chk("rst_busy", 32'(rxBusy), 0);
    chk("rst_ovf", 32'(rxOverflow), 0);

    // Basic burst, then watermark fall
    en = 1'b1;
    ready = 1'b1;
    wm = 1'b1;
    wait_reads(32, "t1_reads");
    @(posedge clk);
    #1;
    r0 = reads;
    wm = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 50 && !fx3_nOE; i++) @(negedge clk);
    chk("t1_noe_hi", 32'(fx3_nOE), 1);
    chk("t1_gap_busy", 32'(rxBusy), 1);
    @(negedge clk);
    chk("t1_gap_idle", 32'(rxBusy), 0);
    chk("t1_idle_noe", 32'(fx3_nOE), 1);
    chk("t1_trail", 32'(reads - r0), 3);
    chk("t1_balance", 32'(writes), 32'(reads));
    chk("t1_sb_empty", 32'(exq.size()), 0);

    // Almost-full mid-burst
    ready = 1'b1;
    wm = 1'b1;
    r0 = reads;
    wait_reads(r0 + 10, "t2_reads");
    @(posedge clk);
    #1;
    r0 = reads;
    af = 1'b1;
    wait_idle("t2_idle");
    chk("t2_trail", 32'(reads - r0), 3);
    r0 = reads;
    repeat (20) @(negedge clk);
    chk("t2_hold_busy", 32'(rxBusy), 0);
    chk("t2_hold_reads", 32'(reads), 32'(r0));
    chk("t2_balance", 32'(writes), 32'(reads));
    af = 1'b0;
    wait_reads(r0 + 4, "t2_resume");
    @(posedge clk);
    #1;
    wm = 1'b0;
    ready = 1'b0;
    wait_idle("t2_end_idle");

    // rxEnable dropped while waiting for the watermark
    ready = 1'b1;
    wait_noe_low("t3_armed");
    r0 = reads;
    @(posedge clk);
    #1;
    ready = 1'b0;
    en = 1'b0;
    wait_idle("t3_idle");
    chk("t3_no_read", 32'(reads), 32'(r0));
    chk("t3_noe", 32'(fx3_nOE), 1);

    // Random flag traffic
    en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      ready = ($urandom_range(0, 9) < 8);
      wm    = ($urandom_range(0, 9) < 7);
      af    = ($urandom_range(0, 9) < 2);
      en    = ($urandom_range(0, 9) < 9);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
    wm = 1'b0;
    af = 1'b0;
    en = 1'b1;
    wait_idle("rnd_idle");
    repeat (6) @(negedge clk);
    chk("rnd_balance", 32'(writes), 32'(reads));
    chk("rnd_sb_empty", 32'(exq.size()), 0);

    // Reset in the middle of a burst
    ready = 1'b1;
    wm = 1'b1;
    wait_reads(reads + 5, "t4_reads");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_noe", 32'(fx3_nOE), 1);
    chk("t4_nrd", 32'(fx3_nRead), 1);
    chk("t4_wr", 32'(fifoWrite), 0);
    chk("t4_data", 32'(fifoData), 0);
    chk("t4_busy", 32'(rxBusy), 0);
    chk("t4_ovf", 32'(rxOverflow), 0);
    ready = 1'b0;
    wm = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_post_busy", 32'(rxBusy), 0);
    chk("t4_post_noe", 32'(fx3_nOE), 1);
    writes = 0;
    reads = 0;

    // Almost-full held long while a read is still issued
    ready = 1'b1;
    wait_noe_low("t5_armed");
    @(posedge clk);
    #1;
    af = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    r0 = reads;
    wm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wm = 1'b0;
    ready = 1'b0;
    wait_idle("t5_idle");
    repeat (4) @(negedge clk);
    chk("t5_one_read", 32'(reads - r0), 1);
    chk("t5_balance", 32'(writes), 32'(reads));
    chk("t5_ovf", 32'(rxOverflow), 32'(EXP_OVF));
    af = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_ovf_sticky", 32'(rxOverflow), 32'(EXP_OVF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fx3_rx_state_machine.md
# fx3_rx_state_machine

Receive-direction companion to the FX3 write state machine. Reads host-to-device data from FX3 GPIF II slave-FIFO thread 1 (sync 16-bit mode) and pushes each word into a local command FIFO. The FPGA is bus master; flow control uses the FX3 thread-ready and watermark flags and the local FIFO almost-full flag. The block shares fx3_clock and the FX3 pads with the write machine; fx3_nOE, fx3_nRead and its FX3 slave-FIFO signals are tied into the shared pad logic.

## Interface
- READ_LATENCY, 2: FX3 clocks from a sampled-low nRead to valid data on fx3_data (1..3).
- DATA_WIDTH, 16: fx3_data / fifoData width.
- fx3_clock  in  1  FX3 interface clock; all logic rising-edge.
- fx3_nReset  in  1  asynchronous, active-low reset.
- fx3_th1Ready  in  1  thread 1 has data (async to logic, resynchronised).
- fx3_th1Watermark  in  1  high = more than watermark words remain in the current buffer.
- fx3_data  in  DATA_WIDTH  FX3 data bus.
- fifoAlmostFull  in  1  local FIFO has ≤ READ_LATENCY+3 free words.
- rxEnable  in  1  level; 0 = finish current burst then idle.
- fx3_nOE  out  1  output enable to FX3, active-low, registered.
- fx3_nRead  out  1  read strobe to FX3, active-low, registered.
- fifoWrite  out  1  one-cycle write strobe to local FIFO.
- fifoData  out  DATA_WIDTH  word accompanying fifoWrite.
- rxBusy  out  1  high in any state other than IDLE.
- rxOverflow  out  1  sticky overflow flag (see Configuration).

## Operation
- Reset values: fx3_nOE=1, fx3_nRead=1, fifoWrite=0, fifoData=0, rxBusy=0, rxOverflow=0; state IDLE; pipeline tracker cleared.
- fx3_th1Ready, fx3_th1Watermark and fifoAlmostFull each pass through one register; all transitions use registered copies.
- States (3-bit):
  - IDLE: → ARM when rxEnable=1, th1Ready=1, fifoAlmostFull=0.
  - ARM: nOE asserted (one cycle before first read); → WAIT_WM.
  - WAIT_WM: hold nOE; → READ when th1Watermark=1; → GAP if th1Ready drops.
  - READ: nOE and nRead asserted; → DRAIN when th1Watermark=0, fifoAlmostFull=1, or rxEnable=0 (first condition seen wins; simultaneous events all just → DRAIN).
  - DRAIN: nRead deasserted, nOE held; wait until the read tracker is empty (READ_LATENCY+1 cycles); → GAP.
  - GAP: nOE deasserted, one idle cycle for bus turnaround; → IDLE.
- Read tracker: shift register of length READ_LATENCY+1 fed with registered ~fx3_nRead. Tail bit = capture strobe. fx3_data is registered every cycle; on tail bit set, fifoWrite=1 and fifoData=registered word.
- Every cycle in which fx3_nRead is sampled low yields exactly one fifoWrite; no word is dropped on DRAIN.
- Illegal state encodings → IDLE next cycle.
- Async reset mid-burst: outputs go to reset values immediately, tracker cleared; in-flight words are discarded (host re-sends).

## Timing
- Flag to state response: 1 cycle of sync + 1 cycle of state + 1 cycle of output register → fx3_nRead changes 2 edges after a flag change is registered.
- Data: fx3_nRead low at edge n → data valid on fx3_data at edge n+READ_LATENCY → fifoWrite at n+READ_LATENCY+1.
- After a watermark fall, up to 3 extra reads are issued; the FX3 watermark is programmed with ≥4 words of slack.
- fifoAlmostFull headroom covers the in-flight reads plus the response delay.

## Configuration
- FX3_RX_OVERFLOW_DETECT_EN defined: rxOverflow sets when fifoWrite=1 while registered fifoAlmostFull has been high for more than READ_LATENCY+2 consecutive cycles (the headroom has been exceeded). It clears only on reset.
- Undefined: no detection logic; rxOverflow tied to 0.

## Test plan
- Basic burst, READ_LATENCY=2: th1Ready=1, watermark high for 32 cycles of READ, words 0x0001..: every issued read → exactly one fifoWrite, data in order, first fifoWrite 3 cycles after first nRead low.
- Watermark fall mid-burst: exactly 3 trailing reads drained; GAP shows nOE=1 for one cycle, then IDLE; the count of fifoWrite equals the count of nRead-low cycles.
- fifoAlmostFull asserted at READ cycle 10 → DRAIN; no fifoWrite after the tracker empties; IDLE until almostFull clears.
- rxEnable dropped during WAIT_WM with th1Ready low → GAP → IDLE with no nRead pulse.
- Reset asserted in READ → all outputs at reset values within the same cycle; after release, IDLE with rxBusy=0.
- With FX3_RX_OVERFLOW_DETECT_EN, a model that ignores almostFull for 6 cycles → rxOverflow=1 and it stays set; without the macro, rxOverflow stays 0.
